// File: rtl/adc_pkg.sv
// Constants shared across the ADC front end: the sample width, the full-scale
// code, and the slice width the comparator reads from the filtered sample.
package adc_pkg;
    localparam int ADC_W   = 12;
    localparam int ADC_MAX = (1 << ADC_W) - 1;
    localparam int CMP_W   = 8;
endpackage

// File: rtl/adc_avg_filter_if.sv
// Interface between the ADC controller, the averaging filter and the comparator.
// The filter sits on the slave side; its stimulus source sits on the master side.
interface adc_avg_filter_if #(
    parameter int DATA_W = adc_pkg::ADC_W
);
    logic [DATA_W-1:0] data_in;
    logic              data_ready;
    logic              clear;
    logic [DATA_W-1:0] avg_data;
    logic              avg_valid;
    logic              primed;

    modport master (
        output data_in, data_ready, clear,
        input  avg_data, avg_valid, primed
    );

    modport slave (
        input  data_in, data_ready, clear,
        output avg_data, avg_valid, primed
    );
endinterface

// File: rtl/adc_avg_filter_sample_ring.sv
// N-entry circular sample buffer. The oldest entry, which sits at the write
// pointer, is read combinationally so it can be replaced on the same edge.
module sample_ring
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_W,
    parameter int LOG2_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              flush,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] oldest
);
    localparam int N = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0]     mem_q [N];
    logic [DATA_W-1:0]     mem_d [N];
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH-1:0] wr_ptr_d;

    assign oldest = mem_q[wr_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            for (int i = 0; i < N; i++) begin
                mem_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            // Pointer width equals log2(N), so the increment wraps modulo N.
            wr_ptr_d        = wr_ptr_q + LOG2_DEPTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end
endmodule

// File: rtl/adc_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_DEPTH accepted ADC samples, kept as
// a running sum so each new sample costs one add and one subtract.
module adc_avg_filter
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_W,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    adc_avg_filter_if.slave  bus
);
    localparam int N      = 1 << LOG2_DEPTH;
    localparam int SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic              accept;
    logic [DATA_W-1:0] oldest;
    logic [SUM_W-1:0]  sum_new;
    logic [FILL_W-1:0] fill_new;

    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic              avg_valid_q, avg_valid_d;
    logic              primed_q, primed_d;

    // A clear in the same cycle as a strobe discards the sample.
    assign accept = bus.data_ready && !bus.clear;

    sample_ring #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .flush   (bus.clear),
        .wr_data (bus.data_in),
        .oldest  (oldest)
    );

    // The sum always covers the evicted entry, so the modular add/subtract is exact.
    assign sum_new  = sum_q + SUM_W'(bus.data_in) - SUM_W'(oldest);
    assign fill_new = (fill_cnt_q == FILL_FULL) ? FILL_FULL : fill_cnt_q + FILL_W'(1);

    always_comb begin
        sum_d       = sum_q;
        fill_cnt_d  = fill_cnt_q;
        avg_data_d  = avg_data_q;
        avg_valid_d = 1'b0;
        primed_d    = primed_q;
        if (bus.clear) begin
            sum_d      = '0;
            fill_cnt_d = '0;
            primed_d   = 1'b0;
        end else if (accept) begin
            sum_d      = sum_new;
            fill_cnt_d = fill_new;
            primed_d   = (fill_new == FILL_FULL);
            if (fill_new == FILL_FULL) begin
                avg_valid_d = 1'b1;
                avg_data_d  = DATA_W'(sum_new >> LOG2_DEPTH);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            fill_cnt_q  <= '0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            fill_cnt_q  <= fill_cnt_d;
            avg_data_q  <= avg_data_d;
            avg_valid_q <= avg_valid_d;
            primed_q    <= primed_d;
        end
    end

    assign bus.avg_data  = avg_data_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.primed    = primed_q;
endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for the moving-average filter with N = 4 and hand-computed
// window means.
module tb_adc_avg_filter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adc_avg_filter_if #(.DATA_W(12)) bus ();

    adc_avg_filter #(
        .DATA_W     (12),
        .LOG2_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [11:0] avg,
                             input logic vld, input logic prm);
        check({tag, ".avg_data"},  {20'd0, bus.avg_data}, {20'd0, avg});
        check({tag, ".avg_valid"}, {31'd0, bus.avg_valid}, {31'd0, vld});
        check({tag, ".primed"},    {31'd0, bus.primed},    {31'd0, prm});
    endtask

    // Strobe one sample; returns on the falling edge after the accepting edge.
    task automatic push(input logic [11:0] v);
        @(negedge clk);
        bus.data_ready = 1'b1;
        bus.data_in    = v;
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.data_in    = 'x;
    endtask

    task automatic sync_reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [11:0] b2b_in  [6] = '{12'd0, 12'd4, 12'd8, 12'd12, 12'd16, 12'd20};
    logic [11:0] b2b_avg [6] = '{12'd0, 12'd0, 12'd0, 12'd6, 12'd10, 12'd14};
    logic        b2b_vld [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.data_in    = 'x;
        bus.data_ready = 1'b0;
        bus.clear      = 1'b0;

        // Strobe during reset must be ignored.
        @(negedge clk);
        bus.data_ready = 1'b1;
        bus.data_in    = 12'd777;
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.data_in    = 'x;
        check_out("reset", 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill
        push(12'd100); check_out("fill1", 12'd0, 1'b0, 1'b0);
        push(12'd200); check_out("fill2", 12'd0, 1'b0, 1'b0);
        push(12'd300); check_out("fill3", 12'd0, 1'b0, 1'b0);
        push(12'd400); check_out("fill4", 12'd250, 1'b1, 1'b1);
        @(negedge clk); check_out("pulse_end", 12'd250, 1'b0, 1'b1);

        // Slide and full scale
        push(12'd500);  check_out("slide500", 12'd350, 1'b1, 1'b1);
        push(12'd4095); check_out("max1", 12'd1323, 1'b1, 1'b1);
        push(12'd4095); check_out("max2", 12'd2272, 1'b1, 1'b1);
        push(12'd4095); check_out("max3", 12'd3196, 1'b1, 1'b1);
        push(12'd4095); check_out("max4", 12'd4095, 1'b1, 1'b1);

        // Clear collides with a strobe: sample dropped, avg_data held
        @(negedge clk);
        bus.clear      = 1'b1;
        bus.data_ready = 1'b1;
        bus.data_in    = 12'd999;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.data_ready = 1'b0;
        bus.data_in    = 'x;
        check_out("clear", 12'd4095, 1'b0, 1'b0);
        push(12'd8); check_out("refill1", 12'd4095, 1'b0, 1'b0);
        push(12'd8); check_out("refill2", 12'd4095, 1'b0, 1'b0);
        push(12'd8); check_out("refill3", 12'd4095, 1'b0, 1'b0);
        push(12'd8); check_out("refill4", 12'd8, 1'b1, 1'b1);

        // Truncation: 5 >> 2 = 1
        sync_reset_pulse();
        check_out("reset2", 12'd0, 1'b0, 1'b0);
        push(12'd1);
        push(12'd1);
        push(12'd1);
        push(12'd2); check_out("trunc", 12'd1, 1'b1, 1'b1);

        // Back-to-back strobes, one result per cycle
        sync_reset_pulse();
        @(negedge clk);
        bus.data_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.data_in = b2b_in[i];
            @(negedge clk);
            check_out($sformatf("b2b%0d", i), b2b_avg[i], b2b_vld[i], i >= 3);
        end
        bus.data_ready = 1'b0;
        bus.data_in    = 'x;

        // Asynchronous reset mid-window, observed before the next clock edge
        push(12'd24);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 12'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push(12'd40); check_out("post1", 12'd0, 1'b0, 1'b0);
        push(12'd40); check_out("post2", 12'd0, 1'b0, 1'b0);
        push(12'd40); check_out("post3", 12'd0, 1'b0, 1'b0);
        push(12'd40); check_out("post4", 12'd40, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
